inst_buffer: RTL and testbench

Decoupling FIFO between the instruction cache and the decode stage. Each cycle it accepts up to two fetched instructions (PC, instruction word, exception info) from the icache output registers and presents up to two oldest entries to decode in program order. It absorbs icache miss bubbles and decode back-pressure, and empties on branch flush.

---
 rtl/pipeline_types.sv | 18 +
 rtl/ibuf_store.sv | 37 +++
 rtl/inst_buffer.sv | 136 +++++++++++++
 tb/tb_inst_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_types.sv
// Shared front-end pipeline types: instruction buffer entry layout and default depth.
package pipeline_types;

  localparam int IBUF_DEPTH   = 16;
  localparam int IBUF_CAUSE_W = 7;

  typedef struct packed {
    logic [31:0]             pc;
    logic [31:0]             inst;
    logic                    is_exc;
    logic [IBUF_CAUSE_W-1:0] exc_cause;
  } ibuf_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/ibuf_store.sv
// Instruction buffer storage: DEPTH entries, two write ports, two asynchronous read ports.
module ibuf_store
  import pipeline_types::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr0_en,
  input  logic [AW-1:0] wr0_addr,
  input  ibuf_entry_t   wr0_data,
  input  logic          wr1_en,
  input  logic [AW-1:0] wr1_addr,
  input  ibuf_entry_t   wr1_data,
  input  logic [AW-1:0] rd0_addr,
  output ibuf_entry_t   rd0_data,
  input  logic [AW-1:0] rd1_addr,
  output ibuf_entry_t   rd1_data
);

  ibuf_entry_t mem [DEPTH];

  // Cleared on reset so invalid head slots never read as X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr0_en) mem[wr0_addr] <= wr0_data;
      if (wr1_en) mem[wr1_addr] <= wr1_data;
    end
  end

  assign rd0_data = mem[rd0_addr];
  assign rd1_data = mem[rd1_addr];

endmodule

// File: rtl/inst_buffer.sv
// Two-in/two-out instruction FIFO between icache and decode.
// Optional INST_BUFFER_STAT_EN adds full/empty cycle counters.
module inst_buffer
  import pipeline_types::*;
#(
  parameter int DEPTH   = IBUF_DEPTH,
  parameter int CAUSE_W = IBUF_CAUSE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [1:0]              in_fetch_en,
  input  logic                    in_stall,
  input  logic [1:0][31:0]        in_pc,
  input  logic [1:0][31:0]        in_inst,
  input  logic [1:0]              in_is_exc,
  input  logic [1:0][CAUSE_W-1:0] in_exc_cause,
  output logic                    buffer_full,
  output logic [1:0]              out_valid,
  output logic [1:0][31:0]        out_pc,
  output logic [1:0][31:0]        out_inst,
  output logic [1:0]              out_is_exc,
  output logic [1:0][CAUSE_W-1:0] out_exc_cause,
  input  logic [1:0]              dec_accept
`ifdef INST_BUFFER_STAT_EN
  ,
  output logic [31:0]             stat_full_cycles,
  output logic [31:0]             stat_empty_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] head, tail, count;
  logic [PW-1:0] head_nxt1, tail_nxt1;
  logic [1:0]    push_mask, pop_mask;
  logic [1:0]    push_n, pop_n;
  logic [PW:0]   next_count;
  logic          push_ok;

  ibuf_entry_t   in_entry [2];
  ibuf_entry_t   wr0_data, wr1_data, rd0_data, rd1_data;
  logic          wr0_en, wr1_en;

  always_comb begin
    push_mask  = in_fetch_en & {2{~in_stall}};
    pop_mask   = dec_accept & out_valid;
    push_n     = popcount2(push_mask);
    pop_n      = popcount2(pop_mask);
    // pop_mask is a subset of out_valid, so count - pop never underflows.
    next_count = {1'b0, count} - (PW+1)'(pop_n) + (PW+1)'(push_n);
    push_ok    = next_count <= (PW+1)'(DEPTH);
    head_nxt1  = head + PW'(1);
    tail_nxt1  = tail + PW'(1);
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      in_entry[s].pc        = in_pc[s];
      in_entry[s].inst      = in_inst[s];
      in_entry[s].is_exc    = in_is_exc[s];
      in_entry[s].exc_cause = in_exc_cause[s];
    end
    // Compaction: a lone slot-1 instruction lands at tail like a slot-0 one.
    wr0_data = push_mask[0] ? in_entry[0] : in_entry[1];
    wr1_data = in_entry[1];
    wr0_en   = (|push_mask) & push_ok & ~flush;
    wr1_en   = (&push_mask) & push_ok & ~flush;
  end

  ibuf_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk      (clk),
    .reset    (reset),
    .wr0_en   (wr0_en),
    .wr0_addr (tail[AW-1:0]),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (tail_nxt1[AW-1:0]),
    .wr1_data (wr1_data),
    .rd0_addr (head[AW-1:0]),
    .rd0_data (rd0_data),
    .rd1_addr (head_nxt1[AW-1:0]),
    .rd1_data (rd1_data)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(pop_n);
      if (push_ok) begin
        tail  <= tail + PW'(push_n);
        count <= next_count[PW-1:0];
      end else begin
        count <= count - PW'(pop_n);
      end
    end
  end

  assign out_valid   = {count >= PW'(2), count != '0};
  assign buffer_full = count >= PW'(DEPTH - 1);

  always_comb begin
    out_pc[0]        = rd0_data.pc;
    out_pc[1]        = rd1_data.pc;
    out_inst[0]      = rd0_data.inst;
    out_inst[1]      = rd1_data.inst;
    out_is_exc       = {rd1_data.is_exc, rd0_data.is_exc};
    out_exc_cause[0] = rd0_data.exc_cause;
    out_exc_cause[1] = rd1_data.exc_cause;
  end

  // Decode must consume a thermometer subset of out_valid.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (dec_accept != 2'b10 && (dec_accept & ~out_valid) == 2'b00)
        else $error("inst_buffer: illegal dec_accept %b with out_valid %b", dec_accept, out_valid);
    end
  end

`ifdef INST_BUFFER_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_full_cycles  <= '0;
      stat_empty_cycles <= '0;
    end else begin
      if (buffer_full) stat_full_cycles <= stat_full_cycles + 32'd1;
      if (count == '0 && !flush) stat_empty_cycles <= stat_empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed table-driven bench for inst_buffer, plus fill/wrap/drain and optional stat sequences.
module tb_inst_buffer;
  import pipeline_types::*;

  localparam int          CW = 7;
  localparam logic [31:0] K  = 32'h5A5A_0000;

  logic                clk = 1'b0;
  logic                reset, flush, in_stall, buffer_full;
  logic [1:0]          in_fetch_en, in_is_exc, out_valid, out_is_exc, dec_accept;
  logic [1:0][31:0]    in_pc, in_inst, out_pc, out_inst;
  logic [1:0][CW-1:0]  in_exc_cause, out_exc_cause;
`ifdef INST_BUFFER_STAT_EN
  logic [31:0]         stat_full_cycles, stat_empty_cycles;
`endif

  int n_vec = 0;
  int n_bad = 0;

  inst_buffer #(.DEPTH(16), .CAUSE_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_fetch_en   (in_fetch_en),
    .in_stall      (in_stall),
    .in_pc         (in_pc),
    .in_inst       (in_inst),
    .in_is_exc     (in_is_exc),
    .in_exc_cause  (in_exc_cause),
    .buffer_full   (buffer_full),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_is_exc    (out_is_exc),
    .out_exc_cause (out_exc_cause),
    .dec_accept    (dec_accept)
`ifdef INST_BUFFER_STAT_EN
    ,
    .stat_full_cycles  (stat_full_cycles),
    .stat_empty_cycles (stat_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        fl;
    logic [1:0]  fe;
    logic        st;
    logic [31:0] p0, p1;
    logic [1:0]  acc;
    logic [1:0]  ev;
    logic        ef;
    logic [31:0] e0, e1;
    int          ec;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic fl, input logic [1:0] fe, input logic st,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] acc);
    flush        = fl;
    in_fetch_en  = fe;
    in_stall     = st;
    in_pc        = {p1, p0};
    in_inst      = {i1, i0};
    in_is_exc    = {p1[2], p0[2]};
    in_exc_cause = {p1[8:2], p0[8:2]};
    dec_accept   = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        2'b11, 2'b00, 1'b0, 32'h0,        32'h0,        0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 32'h1C000104, 2'b00, 2'b01, 1'b0, 32'h1C000104, 32'h0,        1};
    tbl[2]  = '{1'b0, 2'b11, 1'b1, 32'h00000100, 32'h00000104, 2'b00, 2'b01, 1'b0, 32'h1C000104, 32'h0,        1};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        2'b01, 2'b00, 1'b0, 32'h0,        32'h0,        0};
    tbl[4]  = '{1'b0, 2'b11, 1'b0, 32'h1C0000A0, 32'h1C0000A4, 2'b00, 2'b11, 1'b0, 32'h1C0000A0, 32'h1C0000A4, 2};
    tbl[5]  = '{1'b0, 2'b11, 1'b0, 32'h1C0000A8, 32'h1C0000AC, 2'b00, 2'b11, 1'b0, 32'h1C0000A0, 32'h1C0000A4, 4};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h1C0000B0, 32'h0,        2'b00, 2'b11, 1'b0, 32'h1C0000A0, 32'h1C0000A4, 5};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 32'h1C0000B4, 32'h1C0000B8, 2'b11, 2'b11, 1'b0, 32'h1C0000A8, 32'h1C0000AC, 5};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h1C0000C0, 32'h1C0000C4, 2'b00, 2'b11, 1'b0, 32'h1C0000A8, 32'h1C0000AC, 7};
    tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h1C0000C8, 32'h0,        2'b00, 2'b11, 1'b0, 32'h1C0000A8, 32'h1C0000AC, 8};
    tbl[10] = '{1'b1, 2'b11, 1'b0, 32'h1C0000E0, 32'h1C0000E4, 2'b00, 2'b00, 1'b0, 32'h0,        32'h0,        0};
    tbl[11] = '{1'b0, 2'b11, 1'b0, 32'h1C0000D0, 32'h1C0000D4, 2'b00, 2'b11, 1'b0, 32'h1C0000D0, 32'h1C0000D4, 2};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 32'h0,        32'h0,        2'b11, 2'b00, 1'b0, 32'h0,        32'h0,        0};

    do_reset();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset buffer_full", 32'(buffer_full), 32'd0);
    chk("reset out_pc0", out_pc[0], 32'd0);
    chk("reset out_pc1", out_pc[1], 32'd0);
    chk("reset out_inst0", out_inst[0], 32'd0);
    chk("reset count", 32'(dut.count), 32'd0);

    step(1'b0, 2'b11, 1'b0, 32'h1C000000, 32'h1C000004, 32'h02800000, 32'h02800400, 2'b00);
    chk("first push valid", 32'(out_valid), 32'd3);
    chk("first push pc0", out_pc[0], 32'h1C000000);
    chk("first push pc1", out_pc[1], 32'h1C000004);
    chk("first push inst0", out_inst[0], 32'h02800000);
    chk("first push inst1", out_inst[1], 32'h02800400);
    chk("first push count", 32'(dut.count), 32'd2);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].fl, tbl[i].fe, tbl[i].st, tbl[i].p0, tbl[i].p1,
           tbl[i].p0 ^ K, tbl[i].p1 ^ K, tbl[i].acc);
      chk($sformatf("r%0d valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("r%0d full", i), 32'(buffer_full), 32'(tbl[i].ef));
      chk($sformatf("r%0d count", i), 32'(dut.count), 32'(tbl[i].ec));
      if (tbl[i].ev[0]) begin
        chk($sformatf("r%0d pc0", i), out_pc[0], tbl[i].e0);
        chk($sformatf("r%0d inst0", i), out_inst[0], tbl[i].e0 ^ K);
        chk($sformatf("r%0d is_exc0", i), 32'(out_is_exc[0]), 32'(tbl[i].e0[2]));
        chk($sformatf("r%0d cause0", i), 32'(out_exc_cause[0]), 32'(tbl[i].e0[8:2]));
      end
      if (tbl[i].ev[1]) begin
        chk($sformatf("r%0d pc1", i), out_pc[1], tbl[i].e1);
        chk($sformatf("r%0d inst1", i), out_inst[1], tbl[i].e1 ^ K);
        chk($sformatf("r%0d cause1", i), 32'(out_exc_cause[1]), 32'(tbl[i].e1[8:2]));
      end
    end

    // Fill to 15, drop an overflowing pair, top up to 16, then drain across the storage wrap.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 2'b11, 1'b0, 32'h1C00F000 + 32'(8*i), 32'h1C00F004 + 32'(8*i),
           32'h0, 32'h0, 2'b00);
    end
    chk("fill14 count", 32'(dut.count), 32'd14);
    chk("fill14 full", 32'(buffer_full), 32'd0);
    step(1'b0, 2'b01, 1'b0, 32'h1C00F038, 32'h0, 32'h0, 32'h0, 2'b00);
    chk("fill15 count", 32'(dut.count), 32'd15);
    chk("fill15 full", 32'(buffer_full), 32'd1);
    step(1'b0, 2'b11, 1'b0, 32'h0000BAD0, 32'h0000BAD4, 32'h0, 32'h0, 2'b00);
    chk("overflow dropped count", 32'(dut.count), 32'd15);
    step(1'b0, 2'b01, 1'b0, 32'h1C00F03C, 32'h0, 32'h0, 32'h0, 2'b00);
    chk("fill16 count", 32'(dut.count), 32'd16);
    chk("fill16 full", 32'(buffer_full), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d pc0", k), out_pc[0], 32'h1C00F000 + 32'(8*k));
      chk($sformatf("drain%0d pc1", k), out_pc[1], 32'h1C00F004 + 32'(8*k));
      step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11);
      chk($sformatf("drain%0d count", k), 32'(dut.count), 32'(14 - 2*k));
      chk($sformatf("drain%0d full", k), 32'(buffer_full), 32'd0);
    end
    chk("drained valid", 32'(out_valid), 32'd0);

`ifdef INST_BUFFER_STAT_EN
    do_reset();
    chk("stat reset full", stat_full_cycles, 32'd0);
    chk("stat reset empty", stat_empty_cycles, 32'd0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 2'b11, 1'b0, 32'h1C000200 + 32'(8*i), 32'h1C000204 + 32'(8*i),
           32'h0, 32'h0, 2'b00);
    end
    step(1'b0, 2'b01, 1'b0, 32'h1C000238, 32'h0, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < 10; i++) idle();
    chk("stat full cycles", stat_full_cycles, 32'd10);
    chk("stat empty cycles", stat_empty_cycles, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
